// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and constants for the LED sequencer family:
//                pattern mode encoding, chase direction encoding, board clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Board system clock, used to derive prescaler divisors.
  localparam int unsigned CLK_HZ = 12_000_000;

  // Run-time selectable LED pattern; encoding matches the 2-bit mode pins.
  typedef enum logic [1:0] {
    MODE_ALL_ON = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_COUNT  = 2'd3
  } led_mode_t;

  // Direction of the bouncing one-hot in CHASE mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } chase_dir_t;

  // Number of system clock cycles in a given number of milliseconds.
  function automatic int unsigned cycles_per_ms(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_prescaler
//  Description : Free-running clock divider. Counts 0..DIV-1 and wraps,
//                pulsing tick for one cycle on the terminal count. A
//                synchronous clear restarts the count and suppresses any tick
//                coinciding with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
  parameter int unsigned DIV = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // DIV is at least 2, so the counter is always at least one bit wide.
  localparam int unsigned     CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] div_cnt;
  logic             at_last;

  assign at_last = (div_cnt == LAST);

  // Divider count: restarts on clear or after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr || at_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + ONE;
    end
  end

  // A clear in the same cycle wins over the terminal-count pulse.
  assign tick = at_last & ~clr;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer
//  Description : Run-time selectable LED pattern generator with global PWM
//                brightness. Patterns step on a prescaled tick; a change of
//                mode restarts the prescaler and reloads the pattern. The
//                pattern is gated by a free-running PWM comparator and
//                registered onto the LED pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned TICK_DIV = CLK_HZ / 4,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   leds,
  output logic                tick
);

  localparam logic [N_LEDS-1:0]   ALL_ONES = {N_LEDS{1'b1}};
  localparam logic [N_LEDS-1:0]   LED_ONE  = N_LEDS'(1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  // Value a pattern starts from when its mode is entered.
  function automatic logic [N_LEDS-1:0] init_pattern(input led_mode_t m);
    logic [N_LEDS-1:0] v;
    v = ALL_ONES;
    case (m)
      MODE_ALL_ON: v = ALL_ONES;
      MODE_BLINK:  v = ALL_ONES;
      MODE_CHASE:  v = LED_ONE;
      MODE_COUNT:  v = '0;
    endcase
    return v;
  endfunction

  led_mode_t           mode_in;
  led_mode_t           mode_q;
  logic                mode_change;
  logic                step;

  chase_dir_t          dir;
  chase_dir_t          dir_next;
  logic [N_LEDS-1:0]   chase_next;
  logic [N_LEDS-1:0]   pattern;
  logic [N_LEDS-1:0]   pattern_next;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                gate;

  assign mode_in     = led_mode_t'(mode);
  assign mode_change = (mode_in != mode_q);

  // ------------------------------------------------------------------------
  // Pattern step timebase; a mode change restarts it so the first step of a
  // new pattern is a full period away.
  // ------------------------------------------------------------------------
  led_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode_change),
    .tick (step)
  );

  assign tick = step;

  // Track the selected mode so a change can be detected one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_ALL_ON;
    end else begin
      mode_q <= mode_in;
    end
  end

  // ------------------------------------------------------------------------
  // CHASE direction FSM
  // ------------------------------------------------------------------------

  // Direction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_next;
    end
  end

  // Direction turns around when the lit bit sits at either end on a step.
  // A single LED has no ends to bounce between, so it never turns.
  always_comb begin
    dir_next = dir;
    if (mode_change) begin
      dir_next = DIR_UP;
    end else if (step && (mode_q == MODE_CHASE) && (N_LEDS > 1)) begin
      case (dir)
        DIR_UP:   if (pattern[N_LEDS-1]) dir_next = DIR_DOWN;
        DIR_DOWN: if (pattern[0])        dir_next = DIR_UP;
      endcase
    end
  end

  // Shifted one-hot for the next chase step, turning at the end bits.
  always_comb begin
    chase_next = pattern;
    if (N_LEDS > 1) begin
      case (dir)
        DIR_UP:   chase_next = pattern[N_LEDS-1] ? (pattern >> 1) : (pattern << 1);
        DIR_DOWN: chase_next = pattern[0]        ? (pattern << 1) : (pattern >> 1);
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Pattern register
  // ------------------------------------------------------------------------

  // Mode change reloads the new mode's start value; otherwise step on tick.
  always_comb begin
    pattern_next = pattern;
    if (mode_change) begin
      pattern_next = init_pattern(mode_in);
    end else if (step) begin
      case (mode_q)
        MODE_ALL_ON: pattern_next = pattern;
        MODE_BLINK:  pattern_next = ~pattern;
        MODE_CHASE:  pattern_next = chase_next;
        MODE_COUNT:  pattern_next = pattern + LED_ONE;
      endcase
    end
  end

  // Pattern state; reset matches the ALL_ON start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= ALL_ONES;
    end else begin
      pattern <= pattern_next;
    end
  end

  // ------------------------------------------------------------------------
  // PWM brightness and output stage
  // ------------------------------------------------------------------------

  // Free-running PWM phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
    end
  end

  // Full-scale brightness is forced to 100 % instead of (2^N-1)/2^N.
  assign gate = (brightness == PWM_MAX) || (pwm_cnt < brightness);

  // Registered, brightness-gated LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
    end else begin
      leds <= pattern & {N_LEDS{gate}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_sequencer
//  Description : Self-checking bench for led_sequencer (N_LEDS=4 and 1,
//                TICK_DIV=4, PWM_BITS=4). Expected {leds,tick} values are
//                queued when stimulus is applied and popped per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] brightness = 4'd15;
  logic [3:0] leds;
  logic       tick;
  logic [0:0] leds1;
  logic       tick1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] sb[$];

  led_sequencer #(.N_LEDS(4), .TICK_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .brightness(brightness),
    .leds(leds), .tick(tick)
  );

  led_sequencer #(.N_LEDS(1), .TICK_DIV(4), .PWM_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .brightness(brightness),
    .leds(leds1), .tick(tick1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1; mode = 2'd0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0000) begin n_fail++; $display("FAIL reset_leds: got %b want 0000", leds); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_checks++;
    if (leds1 !== 1'b0) begin n_fail++; $display("FAIL reset_leds1: got %b want 0", leds1); end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) sb.push_back({4'b1111, (k % 4 == 3)});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL reset_run_leds k=%0d: got %b want %b", k, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL reset_run_tick k=%0d: got %b want %b", k, tick, e[0]); end
    end
  endtask

  task automatic test_blink();
    logic [4:0] e;
    mode = 2'd1;
    for (int k = 2; k <= 17; k++)
      sb.push_back({(((k - 2) / 4) % 2 == 0) ? 4'b1111 : 4'b0000, (k % 4 == 0)});
    @(negedge clk);
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL blink_leds k=%0d: got %b want %b", k, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL blink_tick k=%0d: got %b want %b", k, tick, e[0]); end
    end
  endtask

  task automatic test_chase();
    logic [4:0] e;
    logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0100, 4'b0010, 4'b0001, 4'b0010};
    mode = 2'd2;
    for (int k = 2; k <= 33; k++) sb.push_back({seq[(k - 2) / 4], (k % 4 == 0)});
    @(negedge clk);
    for (int k = 2; k <= 33; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL chase_leds k=%0d: got %b want %b", k, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL chase_tick k=%0d: got %b want %b", k, tick, e[0]); end
      n_checks++;
      if (leds1 !== 1'b1) begin n_fail++; $display("FAIL chase1_leds k=%0d: got %b want 1", k, leds1); end
    end
  endtask

  task automatic test_count_wrap();
    logic [4:0] e;
    mode = 2'd3;
    for (int k = 2; k <= 73; k++) sb.push_back({4'(((k - 2) / 4) % 16), (k % 4 == 0)});
    @(negedge clk);
    for (int k = 2; k <= 73; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL count_leds k=%0d: got %b want %b", k, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL count_tick k=%0d: got %b want %b", k, tick, e[0]); end
    end
  endtask

  task automatic test_pwm();
    logic [4:0] e;
    int         high;
    mode = 2'd0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    // quarter duty: exactly 4 lit cycles in any 16-cycle window
    brightness = 4'd4;
    sb.push_back(5'd4);
    @(negedge clk);
    high = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (leds === 4'b1111) high++;
      n_checks++;
      if (leds !== 4'b1111 && leds !== 4'b0000) begin
        n_fail++; $display("FAIL pwm4_shape k=%0d: got %b want 0000 or 1111", k, leds);
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (high !== int'(e)) begin n_fail++; $display("FAIL pwm4_duty: got %0d lit cycles want %0d", high, e); end
    // dark and full-on
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 4'd0 : 4'd15;
      for (int k = 0; k < 16; k++) sb.push_back({(b == 0) ? 4'b0000 : 4'b1111, 1'b0});
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (leds !== e[4:1]) begin n_fail++; $display("FAIL pwm_level b=%0d k=%0d: got %b want %b", b, k, leds, e[4:1]); end
      end
    end
    brightness = 4'd15;
  endtask

  task automatic test_mode_change();
    logic [4:0] e;
    mode = 2'd2;
    repeat (7) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0010) begin n_fail++; $display("FAIL mc_pre_leds: got %b want 0010", leds); end
    // switch one cycle before the tick: no step, COUNT start value, restart
    mode = 2'd3;
    sb.push_back({4'b0010, 1'b0});
    sb.push_back({4'b0000, 1'b0});
    sb.push_back({4'b0000, 1'b0});
    sb.push_back({4'b0000, 1'b1});
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL mc_count_leds j=%0d: got %b want %b", j, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL mc_count_tick j=%0d: got %b want %b", j, tick, e[0]); end
    end
    // switch in the tick cycle itself: the change wins, no COUNT step
    mode = 2'd1;
    sb.push_back({4'b0000, 1'b0});
    sb.push_back({4'b1111, 1'b0});
    sb.push_back({4'b1111, 1'b0});
    sb.push_back({4'b1111, 1'b1});
    sb.push_back({4'b1111, 1'b0});
    sb.push_back({4'b0000, 1'b0});
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL mc_override_leds j=%0d: got %b want %b", j, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL mc_override_tick j=%0d: got %b want %b", j, tick, e[0]); end
    end
  endtask

  task automatic test_reset_mid_chase();
    logic [4:0] e;
    mode = 2'd2;
    repeat (10) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0100) begin n_fail++; $display("FAIL mid_pre_leds: got %b want 0100", leds); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (leds !== 4'b0000) begin n_fail++; $display("FAIL mid_async_leds: got %b want 0000", leds); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL mid_async_tick: got %b want 0", tick); end
    n_checks++;
    if (leds1 !== 1'b0) begin n_fail++; $display("FAIL mid_async_leds1: got %b want 0", leds1); end
    repeat (2) @(negedge clk);
    // released with CHASE still selected: ALL_ON reset state, then reload
    rst = 1'b0;
    sb.push_back({4'b1111, 1'b0});
    sb.push_back({4'b0001, 1'b0});
    sb.push_back({4'b0001, 1'b0});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (leds !== e[4:1]) begin n_fail++; $display("FAIL mid_release_leds k=%0d: got %b want %b", k, leds, e[4:1]); end
      n_checks++;
      if (tick !== e[0]) begin n_fail++; $display("FAIL mid_release_tick k=%0d: got %b want %b", k, tick, e[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_chase();
    test_count_wrap();
    test_pwm();
    test_mode_change();
    test_reset_mid_chase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
